// File: rtl/tiny_io_ctrl_if.sv
// TinyComp I/O bus plus device-side RX/TX streams for tiny_io_ctrl.
// master = CPU/device side, slave = controller side.
interface tiny_io_ctrl_if #(
   parameter int NUM_CH = 4
);
   logic [3:0]          IOaddr;
   logic                IOread;
   logic                IOwrite;
   logic [31:0]         OutValue;
   logic [31:0]         InValue;
   logic                InReady;
   logic [NUM_CH*32-1:0] rx_data;
   logic [NUM_CH-1:0]   rx_valid;
   logic [NUM_CH-1:0]   rx_ready;
   logic [31:0]         tx_data;
   logic [3:0]          tx_chan;
   logic                tx_valid;
   logic                tx_ready;

   modport master (
      output IOaddr, IOread, IOwrite, OutValue, rx_data, rx_valid, tx_ready,
      input  InValue, InReady, rx_ready, tx_data, tx_chan, tx_valid
   );

   modport slave (
      input  IOaddr, IOread, IOwrite, OutValue, rx_data, rx_valid, tx_ready,
      output InValue, InReady, rx_ready, tx_data, tx_chan, tx_valid
   );
endinterface

// File: rtl/tiny_io_ctrl.sv
// tiny_io_ctrl: TinyComp I/O port controller with per-channel RX FIFOs and one channel-tagged TX FIFO.
// Optional macro TINY_IO_STATUS_EN maps a status/clear register at channel address 15.
module tiny_io_ctrl #(
   parameter int NUM_CH   = 4,
   parameter int RX_DEPTH = 4,
   parameter int TX_DEPTH = 8
) (
   input  logic          Clock,
   input  logic          Reset_n,
   tiny_io_ctrl_if.slave io
);
   localparam int RXAW = $clog2(RX_DEPTH);
   localparam int RXCW = RXAW + 1;
   localparam int TXAW = $clog2(TX_DEPTH);
   localparam int TXCW = TXAW + 1;
   localparam logic [3:0] STATUS_ADDR = 4'hF;

   logic [NUM_CH-1:0]        rx_empty_s;
   logic [NUM_CH-1:0]        rx_full_s;
   logic [NUM_CH-1:0]        rd_hit_s;
   logic [NUM_CH-1:0][31:0]  rx_head_s;
   logic [31:0]              rd_head_s;
   logic                     rd_ne_s;
   logic [31:0]              in_value_s;
   logic                     in_ready_s;

   logic [35:0]              tx_mem_r [TX_DEPTH];
   logic [TXAW-1:0]          tx_wptr_r;
   logic [TXAW-1:0]          tx_rptr_r;
   logic [TXCW-1:0]          tx_cnt_r;
   logic                     tx_empty_s;
   logic                     tx_full_s;
   logic                     tx_wr_s;
   logic                     tx_push_s;
   logic                     tx_pop_s;

   logic                     ovf_r;
   logic                     udf_r;
   logic                     ovf_set_s;
   logic                     udf_set_s;
   logic                     flag_clr_s;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_rx
      logic [31:0]     mem_r [RX_DEPTH];
      logic [RXAW-1:0] wptr_r;
      logic [RXAW-1:0] rptr_r;
      logic [RXCW-1:0] cnt_r;
      logic            push_s;
      logic            pop_s;

      assign rx_empty_s[k] = (cnt_r == RXCW'(0));
      assign rx_full_s[k]  = (cnt_r == RXCW'(RX_DEPTH));
      assign rx_head_s[k]  = mem_r[rptr_r];
      assign rd_hit_s[k]   = (io.IOaddr == 4'(k));
      assign push_s        = io.rx_valid[k] & ~rx_full_s[k];
      // An empty FIFO never pops, so a same-cycle push on empty is push-only.
      assign pop_s         = io.IOread & rd_hit_s[k] & ~rx_empty_s[k];

      // RX channel storage write
      always_ff @(posedge Clock) begin
         if (push_s) begin
            mem_r[wptr_r] <= io.rx_data[32*k +: 32];
         end
      end

      // RX channel pointers and occupancy
      always_ff @(posedge Clock or negedge Reset_n) begin
         if (!Reset_n) begin
            wptr_r <= RXAW'(0);
            rptr_r <= RXAW'(0);
            cnt_r  <= RXCW'(0);
         end else begin
            wptr_r <= push_s ? wptr_r + RXAW'(1) : wptr_r;
            rptr_r <= pop_s  ? rptr_r + RXAW'(1) : rptr_r;
            case ({push_s, pop_s})
               2'b10:   cnt_r <= cnt_r + RXCW'(1);
               2'b01:   cnt_r <= cnt_r - RXCW'(1);
               default: cnt_r <= cnt_r;
            endcase
         end
      end
   end

   // Zero-latency read mux over the addressed RX FIFO head
   always_comb begin
      rd_head_s = 32'h0;
      for (int k = 0; k < NUM_CH; k++) begin
         rd_head_s = rd_head_s | ({32{rd_hit_s[k] & ~rx_empty_s[k]}} & rx_head_s[k]);
      end
      rd_ne_s = |(rd_hit_s & ~rx_empty_s);
   end

`ifdef TINY_IO_STATUS_EN
   logic        rd_status_s;
   logic [31:0] status_word_s;

   assign rd_status_s = (io.IOaddr == STATUS_ADDR);

   // Status register image
   always_comb begin
      status_word_s             = 32'h0;
      status_word_s[NUM_CH-1:0] = ~rx_empty_s;
      status_word_s[16]         = tx_full_s;
      status_word_s[17]         = tx_empty_s;
      status_word_s[24]         = ovf_r;
      status_word_s[25]         = udf_r;
   end

   // CPU read data select with status register at address 15
   always_comb begin
      in_value_s = rd_head_s;
      in_ready_s = rd_ne_s;
      if (rd_status_s) begin
         in_value_s = status_word_s;
         in_ready_s = 1'b1;
      end else begin
         in_value_s = rd_head_s;
         in_ready_s = rd_ne_s;
      end
   end

   assign udf_set_s  = io.IOread & ~rd_ne_s & ~rd_status_s;
   assign flag_clr_s = io.IOwrite & rd_status_s;
`else
   assign in_value_s = rd_head_s;
   assign in_ready_s = rd_ne_s;
   assign udf_set_s  = io.IOread & ~rd_ne_s;
   assign flag_clr_s = 1'b0;
`endif

   assign io.InValue  = in_value_s;
   assign io.InReady  = in_ready_s;
   assign io.rx_ready = ~rx_full_s;

   assign tx_empty_s = (tx_cnt_r == TXCW'(0));
   assign tx_full_s  = (tx_cnt_r == TXCW'(TX_DEPTH));
   assign tx_wr_s    = io.IOwrite & (io.IOaddr != STATUS_ADDR);
   // Full is judged on pre-edge state, so a concurrent pop cannot rescue a push.
   assign tx_push_s  = tx_wr_s & ~tx_full_s;
   assign ovf_set_s  = tx_wr_s & tx_full_s;
   assign tx_pop_s   = ~tx_empty_s & io.tx_ready;

   assign io.tx_valid = ~tx_empty_s;
   assign io.tx_data  = tx_empty_s ? 32'h0 : tx_mem_r[tx_rptr_r][31:0];
   assign io.tx_chan  = tx_empty_s ? 4'h0  : tx_mem_r[tx_rptr_r][35:32];

   // TX storage write
   always_ff @(posedge Clock) begin
      if (tx_push_s) begin
         tx_mem_r[tx_wptr_r] <= {io.IOaddr, io.OutValue};
      end
   end

   // TX pointers and occupancy
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         tx_wptr_r <= TXAW'(0);
         tx_rptr_r <= TXAW'(0);
         tx_cnt_r  <= TXCW'(0);
      end else begin
         tx_wptr_r <= tx_push_s ? tx_wptr_r + TXAW'(1) : tx_wptr_r;
         tx_rptr_r <= tx_pop_s  ? tx_rptr_r + TXAW'(1) : tx_rptr_r;
         case ({tx_push_s, tx_pop_s})
            2'b10:   tx_cnt_r <= tx_cnt_r + TXCW'(1);
            2'b01:   tx_cnt_r <= tx_cnt_r - TXCW'(1);
            default: tx_cnt_r <= tx_cnt_r;
         endcase
      end
   end

   // Sticky error flags; a same-cycle set beats the clear
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_set_s ? 1'b1 : (flag_clr_s ? 1'b0 : ovf_r);
         udf_r <= udf_set_s ? 1'b1 : (flag_clr_s ? 1'b0 : udf_r);
      end
   end
endmodule

// File: doc/tiny_io_ctrl.md
Name: tiny_io_ctrl

Overview:
- I/O port controller between the TinyComp CPU I/O bus (IOaddr/IOread/IOwrite/OutValue/InValue/InReady) and a set of peripheral devices.
- Buffers each device's input stream in a per-channel RX FIFO and serves CPU Input instructions from the addressed FIFO.
- Collects CPU Output instructions in one shared, channel-tagged TX FIFO that drains to the devices over a valid/ready handshake.
- Owns the sharing of the CPU's single I/O port among up to 15 devices.

Parameters:
- NUM_CH, 4, number of device channels, 1..15; channel address 15 is reserved.
- RX_DEPTH, 4, entries per RX FIFO, power of 2, >= 2.
- TX_DEPTH, 8, entries in the shared TX FIFO, power of 2, >= 2.

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- IOaddr  in  4  channel address from CPU.
- IOread  in  1  CPU executing Input this cycle.
- IOwrite  in  1  CPU executing Output this cycle.
- OutValue  in  32  CPU output data.
- InValue  out  32  data returned to CPU.
- InReady  out  1  addressed channel has data.
- rx_data  in  NUM_CH*32  device input words; channel k at [32k+31:32k].
- rx_valid  in  NUM_CH  device word valid, per channel.
- rx_ready  out  NUM_CH  RX FIFO k not full.
- tx_data  out  32  head word of TX FIFO.
- tx_chan  out  4  destination channel of head word.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  device accepts head word.

Behaviour:
- Reset (Reset_n low, async):
  - All FIFO pointers and counts cleared; sticky flags cleared.
  - Outputs: tx_valid=0, rx_ready all 1, tx_data=0, tx_chan=0.
  - InValue and InReady follow the decode rules below.
  - Reset asserted mid-transfer discards all buffered data; no partial words survive.
- RX channel k:
  - Push on a rising edge when rx_valid[k] & rx_ready[k].
  - rx_ready[k] = ~full_k, derived from registered state only; no combinational path from any input.
- CPU read decode, combinational, zero latency (the CPU captures InValue at the same edge):
  - IOaddr < NUM_CH: InValue = head of RX FIFO[IOaddr], or 0 if empty. InReady = ~empty[IOaddr].
  - IOaddr >= NUM_CH and != 15: InValue = 0, InReady = 0.
  - InReady is driven every cycle regardless of IOread, because the CPU skip logic samples it on non-I/O instructions.
- Pop:
  - IOread & IOaddr < NUM_CH & ~empty pops at the edge.
  - IOread on an empty or unmapped channel: no pop, sets sticky rx_underflow.
- Simultaneous push and pop on one RX FIFO:
  - Non-empty: both occur, count unchanged.
  - Empty: push only; no bypass, InValue=0 that cycle, underflow flagged.
- CPU write:
  - IOwrite & IOaddr != 15: push {IOaddr, OutValue} into TX FIFO if not full.
  - If full: word dropped, sticky tx_overflow set.
  - IOwrite to addresses >= NUM_CH (except 15) is also pushed; the device side decodes tx_chan.
- TX drain:
  - tx_valid = ~tx_empty.
  - Pop on edge when tx_valid & tx_ready.
  - tx_data/tx_chan show the head entry, held stable while tx_valid & ~tx_ready.
  - Push and pop in the same cycle: full is evaluated on the pre-edge state, so a push is dropped when full even if a pop occurs; a pop and push when not full leaves count unchanged.
- FIFO pointers wrap modulo depth. Count widths are clog2(depth)+1 so the full case is distinguishable.
- IOread and IOwrite are never asserted together; if they are, both actions are performed independently.

Optional Feature:
- Macro TINY_IO_STATUS_EN.
- Defined: channel 15 is a status register.
  - Read: InReady=1, InValue bits [NUM_CH-1:0] = RX non-empty flags, bit16 = tx full, bit17 = tx empty, bit24 = tx_overflow, bit25 = rx_underflow, all other bits 0.
  - IOread to 15 does not flag underflow.
  - IOwrite to 15 clears both sticky flags; a flag set in that same cycle wins over the clear.
- Not defined: channel 15 behaves as unmapped.
  - Reads return 0 with InReady=0 and set underflow.
  - Writes are dropped silently.
  - Sticky flags exist internally but are unobservable.

Test Plan:
- Reset, then drive rx_valid[1] with 0xDEADBEEF; IOaddr=1 -> InReady=1, InValue=0xDEADBEEF. IOread one cycle -> InReady=0 next cycle.
- Push 4 words into channel 0 with RX_DEPTH=4 -> rx_ready[0]=0. Pop one -> rx_ready[0]=1 the following cycle, and words are read back in order.
- Hold tx_ready=0 and issue 9 IOwrites to channel 2 with values 1..9 -> tx_valid=1, tx_chan=2, tx_data=1 stable. Word 9 dropped; status bit24=1 (TINY_IO_STATUS_EN).
- IOread on empty channel 3 -> InValue=0, no pointer change, status bit25=1. IOwrite to 15 -> status bits 24/25 read 0.
- Channel 0 holding 2 words: simultaneous rx push and CPU pop for 5 cycles -> count stays 2 and FIFO order is preserved. Assert Reset_n low mid-sequence -> all FIFOs empty, tx_valid=0 immediately.
- IOaddr=7 with NUM_CH=4 -> InReady=0, InValue=0. IOwrite to 7 -> TX entry with tx_chan=7.
